// File: rtl/gps_pkg.sv
// Code-period constants shared by the C/A upsampler and the correlator.
package gps_pkg;

   localparam int CODE_SHIFT_WIDTH = 15;

   typedef logic [CODE_SHIFT_WIDTH-1:0] code_shift_t;

   localparam code_shift_t CODE_PERIOD_LAST = 15'd16799;
   localparam code_shift_t CODE_PERIOD_LEN  = 15'd16800;

   function automatic logic is_period_last(input code_shift_t shift);
      return shift == CODE_PERIOD_LAST;
   endfunction

endpackage

// File: rtl/sat_accumulator.sv
// Signed saturating accumulator. Once it clamps, it holds the rail until cleared.
// sum is the running total including this cycle's value when add_en is high.
module sat_accumulator #(
   parameter int IN_WIDTH  = 4,
   parameter int ACC_WIDTH = 16
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        add_en,
   input  logic                        clear,
   input  logic signed [IN_WIDTH-1:0]  value,
   output logic signed [ACC_WIDTH-1:0] sum
);

   localparam int WIDE = ACC_WIDTH + 1;

   logic signed [ACC_WIDTH-1:0] total;
   logic                        pinned;
   logic signed [WIDE-1:0]      wide_sum;
   logic                        overflow;

   function automatic logic signed [ACC_WIDTH-1:0] saturate(input logic signed [WIDE-1:0] x);
      if (x[WIDE-1] != x[WIDE-2])
         return x[WIDE-1] ? {1'b1, {(ACC_WIDTH-1){1'b0}}} : {1'b0, {(ACC_WIDTH-1){1'b1}}};
      return x[ACC_WIDTH-1:0];
   endfunction

   assign wide_sum = {total[ACC_WIDTH-1], total}
                   + {{(WIDE-IN_WIDTH){value[IN_WIDTH-1]}}, value};
   assign overflow = wide_sum[WIDE-1] ^ wide_sum[WIDE-2];
   assign sum      = (add_en && !pinned) ? saturate(wide_sum) : total;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         total  <= '0;
         pinned <= 1'b0;
      end else if (clear) begin
         total  <= '0;
         pinned <= 1'b0;
      end else if (add_en) begin
         total  <= sum;
         pinned <= pinned | overflow;
      end
   end

endmodule

// File: rtl/ca_correlator.sv
// Integrate-and-dump correlator: wipes the C/A chip off I/Q samples, sums one
// code period, and hands saturated sums plus a sample count over valid/ready.
module ca_correlator
   import gps_pkg::*;
#(
   parameter int SAMPLE_WIDTH = 3,
   parameter int ACC_WIDTH    = 16
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           enable,
   input  logic                           seeking,
   input  logic signed [SAMPLE_WIDTH-1:0] sample_i,
   input  logic signed [SAMPLE_WIDTH-1:0] sample_q,
   input  logic                           code,
   input  logic [CODE_SHIFT_WIDTH-1:0]    code_shift,
   output logic signed [ACC_WIDTH-1:0]    acc_i,
   output logic signed [ACC_WIDTH-1:0]    acc_q,
   output logic [CODE_SHIFT_WIDTH-1:0]    acc_count,
   output logic                           acc_valid,
   input  logic                           acc_ready,
   output logic                           overrun,
   input  logic                           clear_overrun
);

   localparam int PROD_WIDTH = SAMPLE_WIDTH + 1;

   // One extra bit so negating the most negative sample cannot wrap.
   function automatic logic signed [PROD_WIDTH-1:0] chip_product(
      input logic signed [SAMPLE_WIDTH-1:0] sample,
      input logic                           chip
   );
      logic signed [PROD_WIDTH-1:0] wide;
      wide = {sample[SAMPLE_WIDTH-1], sample};
      return chip ? -wide : wide;
   endfunction

   function automatic code_shift_t count_inc(input code_shift_t cnt);
      return (cnt >= CODE_PERIOD_LEN) ? cnt : cnt + 1'b1;
   endfunction

   logic signed [PROD_WIDTH-1:0] prod_i;
   logic signed [PROD_WIDTH-1:0] prod_q;
   logic signed [ACC_WIDTH-1:0]  next_i;
   logic signed [ACC_WIDTH-1:0]  next_q;
   code_shift_t                  run_cnt;
   code_shift_t                  cnt_next;
   logic                         accumulate;
   logic                         dump;
   logic                         consume;
   logic                         run_clear;

   assign prod_i     = chip_product(sample_i, code);
   assign prod_q     = chip_product(sample_q, code);
   assign accumulate = enable && !seeking;
   assign dump       = accumulate && is_period_last(code_shift);
   assign consume    = acc_valid && acc_ready;
   assign run_clear  = seeking || dump;
   assign cnt_next   = count_inc(run_cnt);

   sat_accumulator #(
      .IN_WIDTH  (PROD_WIDTH),
      .ACC_WIDTH (ACC_WIDTH)
   ) u_acc_i (
      .clk    (clk),
      .reset  (reset),
      .add_en (accumulate),
      .clear  (run_clear),
      .value  (prod_i),
      .sum    (next_i)
   );

   sat_accumulator #(
      .IN_WIDTH  (PROD_WIDTH),
      .ACC_WIDTH (ACC_WIDTH)
   ) u_acc_q (
      .clk    (clk),
      .reset  (reset),
      .add_en (accumulate),
      .clear  (run_clear),
      .value  (prod_q),
      .sum    (next_q)
   );

   // Seeking holds the partial epoch at zero; the dump cycle restarts from zero.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         run_cnt <= '0;
      else if (run_clear)
         run_cnt <= '0;
      else if (accumulate)
         run_cnt <= cnt_next;
   end

   // Dump stage: a new epoch result always wins over a pending one.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         acc_i     <= '0;
         acc_q     <= '0;
         acc_count <= '0;
         acc_valid <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         if (dump) begin
            acc_i     <= next_i;
            acc_q     <= next_q;
            acc_count <= cnt_next;
            acc_valid <= 1'b1;
         end else if (consume) begin
            acc_valid <= 1'b0;
         end
         if (dump && acc_valid && !acc_ready)
            overrun <= 1'b1;
         else if (clear_overrun)
            overrun <= 1'b0;
      end
   end

endmodule

// File: doc/ca_correlator.md
# ca_correlator

Integrate-and-dump correlator directly downstream of the C/A upsampler. Each enabled cycle it multiplies the baseband I/Q sample by the upsampled C/A chip (±1). It accumulates the products over one code period (code_shift 0..16799, 1 ms at 16.8 MHz). At the period boundary it dumps saturated I/Q sums and a sample count to the tracking loop through a valid/ready handshake.

## Interface
- SAMPLE_WIDTH, 3: signed two's-complement width of sample_i/sample_q.
- ACC_WIDTH, 16: signed width of accumulators and dumped results.
- clk  in  1  sample clock (16.8 MHz domain shared with the upsampler).
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  sample valid; same strobe that advances the upsampler.
- seeking  in  1  upsampler seek in progress; suppresses accumulation.
- sample_i, sample_q  in  SAMPLE_WIDTH  signed baseband samples.
- code  in  1  C/A chip from the upsampler: 0 → +1, 1 → −1.
- code_shift  in  15  current code phase, 0..16799, aligned with code.
- acc_i, acc_q  out  ACC_WIDTH  dumped signed sums for the last epoch.
- acc_count  out  15  number of samples accumulated in the dumped epoch.
- acc_valid  out  1  dumped result available.
- acc_ready  in  1  consumer accepts the result.
- overrun  out  1  sticky: a dump overwrote an unaccepted result.
- clear_overrun  in  1  synchronous clear of overrun.

## Operation
- Product width is SAMPLE_WIDTH+1. Compute product = code ? −sample : sample. Negating −2^(SAMPLE_WIDTH−1) yields +2^(SAMPLE_WIDTH−1) with no wrap.
- Accumulate when enable && !seeking: run_i += product_i, run_q += product_q, run_cnt += 1. Sums saturate to [−2^(ACC_WIDTH−1), 2^(ACC_WIDTH−1)−1] and stay clamped for the rest of the epoch.
- run_cnt saturates at 16800.
- Dump when an accumulating cycle has code_shift == 16799:
  - acc_i/acc_q/acc_count ← run values including this cycle's product.
  - run_* ← 0.
  - acc_valid ← 1.
- While seeking == 1, run_* are held at 0. The partial epoch is discarded. The first epoch after a seek dumps with acc_count < 16800.
- Handshake:
  - A result is consumed on a cycle where acc_valid && acc_ready.
  - When consumed with no simultaneous dump, acc_valid ← 0.
  - Outputs are stable while acc_valid && !acc_ready.
- Dump while acc_valid && !acc_ready: the new result overwrites the old one, acc_valid stays 1, and overrun ← 1.
- Dump and consume in the same cycle: the new result loads, acc_valid stays 1, and overrun is unchanged.
- If clear_overrun and an overrun event occur together, set wins.
- enable low means nothing changes. code_shift values between samples are ignored.

## Timing
- Reset value is 0 for every output and internal register. Reset is honoured mid-epoch and discards all state asynchronously.
- Dump latency: acc_valid and results update on the clock edge that samples the code_shift == 16799 accumulating cycle, so they are visible the next cycle.
- overrun updates on the same edge as the offending dump.
- Accumulation has zero bubble: the sample on the dump cycle belongs to the dumped epoch. The next enabled sample (code_shift 0) starts the new epoch.
- Single register stage; no combinational path from acc_ready to any output.

## Structure
- Shared package gps_pkg holds:
  - CODE_SHIFT_WIDTH = 15
  - CODE_PERIOD_LAST = 16799
  - CODE_PERIOD_LEN = 16800
- Sub-module sat_accumulator (parameters IN_WIDTH, ACC_WIDTH; inputs add_en, clear, value; outputs sum). It performs a saturating signed add with a synchronous clear. The correlator instantiates it twice (I and Q).
- Dump/handshake/overrun logic lives in the top module.

## Test plan
- Full epoch, code=0, sample_i=+1, sample_q=−2, code_shift 0..16799 continuous → acc_i=16800, acc_q=−32768 (saturated), acc_count=16800, acc_valid=1 one cycle after the last sample.
- Partial epoch after seek: seeking=1 through code_shift 16699, then 100 samples 16700..16799 with code=1 and sample_i=−4 → acc_i=+400, acc_q=0, acc_count=100.
- Alternating code 0/1 with constant sample_i=+3 over a full epoch → acc_i=0. Repeat with sample_i following the code sign → acc_i=+32767 (saturated).
- acc_ready held 0 across two dumps → second result is visible, overrun=1. Pulse clear_overrun → overrun=0. Dump coincident with acc_ready=1 → acc_valid stays 1, overrun stays 0.
- enable toggled every other cycle across an epoch → acc_count=16800 regardless of gaps, and results equal the continuous case.
- Assert reset (low) mid-epoch at code_shift 8000, release, run to 16799 → all outputs 0 during reset. The next dump counts only post-reset samples (acc_count=8800).
